// File: rtl/instr_encoder.sv
// Field-level MIPS instruction encoder feeding a small FIFO that streams
// encoded words into consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IM_AW = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_kind,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [15:0]      req_imm16,
  input  logic [25:0]      req_imm26,
  output logic             im_we,
  input  logic             im_ready,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic             empty,
  output logic             err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ADDU = 4'd1,
    K_SUBU = 4'd2,
    K_ORI  = 4'd3,
    K_LUI  = 4'd4,
    K_LW   = 4'd5,
    K_SW   = 4'd6,
    K_BEQ  = 4'd7,
    K_J    = 4'd8,
    K_JAL  = 4'd9,
    K_JR   = 4'd10
  } kind_e;

  logic [31:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IM_AW-1:0] addr_q, addr_d;
  logic             err_q, err_d;

  logic [31:0]      enc_word_c;
  logic             legal_c;
  logic             full_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;

  // Pack request fields into a MIPS word; fields a kind does not use stay zero.
  always_comb begin
    enc_word_c = 32'h0;
    legal_c    = 1'b1;
    case (req_kind)
      K_NOP:  enc_word_c = 32'h0;
      K_ADDU: enc_word_c = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h21};
      K_SUBU: enc_word_c = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h23};
      K_ORI:  enc_word_c = {6'h0D, req_rs, req_rt, req_imm16};
      K_LUI:  enc_word_c = {6'h0F, 5'h00, req_rt, req_imm16};
      K_LW:   enc_word_c = {6'h23, req_rs, req_rt, req_imm16};
      K_SW:   enc_word_c = {6'h2B, req_rs, req_rt, req_imm16};
      K_BEQ:  enc_word_c = {6'h04, req_rs, req_rt, req_imm16};
      K_J:    enc_word_c = {6'h02, req_imm26};
      K_JAL:  enc_word_c = {6'h03, req_imm26};
      K_JR:   enc_word_c = {6'h00, req_rs, 15'h0000, 6'h08};
      default: legal_c = 1'b0;
    endcase
  end

  // Handshake decode; illegal kinds are consumed without occupying a slot.
  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
    req_ready = !full_c && !flush;
    accept_c  = req_valid && req_ready;
    push_c    = accept_c && legal_c;
    pop_c     = (count_q != CW'(0)) && im_ready;
  end

  // Next-state for pointers, occupancy, write address and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = '0;
      err_d    = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        addr_d   = addr_q + IM_AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (accept_c && !legal_c) begin
        err_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push_c && !flush) begin
      mem_q[wr_ptr_q] <= enc_word_c;
    end
  end

  // Output view of the FIFO head and write counter.
  always_comb begin
    im_we    = (count_q != CW'(0));
    empty    = (count_q == CW'(0));
    im_wdata = mem_q[rd_ptr_q];
    im_addr  = addr_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: default-width and 2-bit-address
// instances share stimulus so address wrap is observed alongside normal flow.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm16;
  logic [25:0] req_imm26;
  logic        im_ready;

  logic        req_ready, im_we, empty, err;
  logic [11:0] im_addr;
  logic [31:0] im_wdata;

  logic        w_req_ready, w_im_we, w_empty, w_err;
  logic [1:0]  w_im_addr;
  logic [31:0] w_im_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  int          exp_addr;
  logic        err_exp;
  logic [31:0] pend_word;
  logic        pend_legal;
  logic        accepted;

  instr_encoder #(.DEPTH(DEPTH), .IM_AW(12)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm16(req_imm16), .req_imm26(req_imm26),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .empty(empty), .err(err)
  );

  instr_encoder #(.DEPTH(DEPTH), .IM_AW(2)) u_wrap (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(w_req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm16(req_imm16), .req_imm26(req_imm26),
    .im_we(w_im_we), .im_ready(im_ready), .im_addr(w_im_addr),
    .im_wdata(w_im_wdata), .empty(w_empty), .err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance model across the edge.
  task automatic cyc();
    logic rdy_exp, do_pop, do_push;
    logic [11:0] a12;
    logic [1:0]  a2;
    #1;
    rdy_exp = (exp_q.size() < DEPTH) && !flush;
    chk("req_ready", 32'(req_ready), 32'(rdy_exp));
    chk("w_req_ready", 32'(w_req_ready), 32'(rdy_exp));
    chk("im_we", 32'(im_we), 32'(exp_q.size() != 0));
    chk("w_im_we", 32'(w_im_we), 32'(exp_q.size() != 0));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("err", 32'(err), 32'(err_exp));
    chk("w_err", 32'(w_err), 32'(err_exp));
    if (exp_q.size() != 0) begin
      a12 = 12'(exp_addr);
      a2  = 2'(exp_addr);
      chk("im_wdata", im_wdata, exp_q[0]);
      chk("w_im_wdata", w_im_wdata, exp_q[0]);
      chk("im_addr", 32'(im_addr), 32'(a12));
      chk("w_im_addr", 32'(w_im_addr), 32'(a2));
    end
    do_pop   = (exp_q.size() != 0) && im_ready;
    do_push  = req_valid && rdy_exp;
    accepted = do_push;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      exp_addr = 0;
      err_exp  = 1'b0;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        exp_addr++;
      end
      if (do_push) begin
        if (pend_legal) exp_q.push_back(pend_word);
        else            err_exp = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] word, input logic legal);
    int n;
    req_kind   = kind;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_imm16  = i16;
    req_imm26  = i26;
    pend_word  = word;
    pend_legal = legal;
    req_valid  = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 20) begin
      cyc();
      n++;
    end
    req_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed not-accepted expected accepted");
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_kind = 4'd0;
    req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_imm16 = 16'd0; req_imm26 = 26'd0;
    im_ready = 1'b1; exp_addr = 0; err_exp = 1'b0; pend_word = 32'h0; pend_legal = 1'b1;
    accepted = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_w_im_wdata", w_im_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // ADDU
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821, 1'b1);
    idle(3);

    // ORI then LUI, addresses from 0
    do_flush();
    send(4'd3, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h34011234, 1'b1);
    send(4'd4, 5'd7, 5'd8, 5'd9, 16'hFFFF, 26'h0, 32'h3C08FFFF, 1'b1);
    idle(3);

    // Remaining encodings, unused fields driven nonzero
    do_flush();
    send(4'd6, 5'd29, 5'd2, 5'd5, 16'h0004, 26'h3FFFFFF, 32'hAFA20004, 1'b1);
    send(4'd7, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h1, 32'h1022FFFF, 1'b1);
    send(4'd9, 5'd3, 5'd4, 5'd5, 16'hAAAA, 26'h0000C00, 32'h0C000C00, 1'b1);
    send(4'd10, 5'd31, 5'd7, 5'd9, 16'h5555, 26'h123, 32'h03E00008, 1'b1);
    send(4'd2, 5'd4, 5'd5, 5'd6, 16'h1111, 26'h0, 32'h00853023, 1'b1);
    send(4'd5, 5'd4, 5'd5, 5'd6, 16'h8000, 26'h0, 32'h8C858000, 1'b1);
    send(4'd8, 5'd4, 5'd5, 5'd6, 16'h8000, 26'h2ABCDEF, 32'h0AABCDEF, 1'b1);
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'h8000, 26'h2ABCDEF, 32'h00000000, 1'b1);
    idle(4);

    // Backpressure: 4 fill the FIFO, 5th waits; drain shows 0..4 (wrap 0,1,2,3,0)
    do_flush();
    im_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, {6'd0, 5'(i), 5'd2, 5'd3, 5'd0, 6'h21}, 1'b1);
    req_valid = 1'b1; req_rs = 5'd4; pend_word = {6'd0, 5'd4, 5'd2, 5'd3, 5'd0, 6'h21};
    idle(2);
    #1;
    chk("full_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    im_ready = 1'b1;
    send(4'd1, 5'd4, 5'd2, 5'd3, 16'h0, 26'h0, {6'd0, 5'd4, 5'd2, 5'd3, 5'd0, 6'h21}, 1'b1);
    idle(6);
    chk("bp_final_addr", 32'(im_addr), 32'd5);
    chk("bp_final_w_addr", 32'(w_im_addr), 32'd1);

    // Illegal kind between two ADDUs
    do_flush();
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821, 1'b1);
    send(4'd12, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h0, 32'h0, 1'b0);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853021, 1'b1);
    idle(4);
    chk("ill_addr", 32'(im_addr), 32'd2);
    chk("ill_err", 32'(err), 32'd1);
    do_flush();
    idle(1);

    // Reset mid-drain
    do_flush();
    im_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(4'd1, 5'(i + 8), 5'd2, 5'd3, 16'h0, 26'h0, {6'd0, 5'(i + 8), 5'd2, 5'd3, 5'd0, 6'h21}, 1'b1);
    im_ready = 1'b1;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_im_we", 32'(im_we), 32'd0);
    chk("mid_rst_im_addr", 32'(im_addr), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    exp_q.delete();
    exp_addr = 0;
    err_exp  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821, 1'b1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
